// File: rtl/obu_stream_writer.sv
// ---------------------------------------------------------------------------
// obu_stream_writer
// Purpose: serialises one AV1 OBU per command (header byte, optional
// extension byte, LEB128 size, payload bytes) into PARSER_DATA_WIDTH-bit
// words, first byte in the MSBs. Every OBU starts on a fresh word.
//
// Optional feature macro: OBU_WRITER_EXT_HDR_EN (adds the extension header
// ports and the extension byte).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_obu_type        AV1 obu_type
//   cmd_size            payload byte count
//   cmd_ext_en, cmd_temporal_id, cmd_spatial_id   (macro only)
//   pay_valid/ready     payload byte handshake, pay_byte data
//   out_data/out_push   packed word and its one-cycle push strobe
//   out_full            downstream FIFO full (push suppressed)
//   out_start/out_last  first/final word of the OBU
//   out_last_len        valid bits in the final word (0 = whole word)
// ---------------------------------------------------------------------------
package obu_stream_writer_pkg;
  localparam int unsigned PARSER_DATA_WIDTH = 32;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned OBU_TYPE_W        = 4;
  localparam int unsigned OBU_SIZE_W        = 28;
  localparam int unsigned LAST_LEN_W        = 5;

  // Word waiting to be pushed downstream, with its framing flags.
  typedef struct packed {
    logic [PARSER_DATA_WIDTH-1:0] data;
    logic                         start;
    logic                         last;
    logic [LAST_LEN_W-1:0]        len;
  } obu_word_t;
endpackage

module obu_stream_writer
  import obu_stream_writer_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [OBU_TYPE_W-1:0]        cmd_obu_type,
  input  logic [OBU_SIZE_W-1:0]        cmd_size,
`ifdef OBU_WRITER_EXT_HDR_EN
  input  logic                         cmd_ext_en,
  input  logic [2:0]                   cmd_temporal_id,
  input  logic [1:0]                   cmd_spatial_id,
`endif
  input  logic                         pay_valid,
  output logic                         pay_ready,
  input  logic [BYTE_W-1:0]            pay_byte,
  output logic [PARSER_DATA_WIDTH-1:0] out_data,
  output logic                         out_push,
  input  logic                         out_full,
  output logic                         out_start,
  output logic                         out_last,
  output logic [LAST_LEN_W-1:0]        out_last_len
);

  localparam int unsigned ACC_BYTES = PARSER_DATA_WIDTH / BYTE_W;
  localparam int unsigned CNT_W     = 3;
  localparam logic [CNT_W-1:0] ACC_FULL = CNT_W'(ACC_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_EXT, S_SIZE, S_PAYLOAD, S_FLUSH
  } state_t;

  state_t                       r_state, w_state_nxt;
  logic [OBU_TYPE_W-1:0]        r_type;
  logic [OBU_SIZE_W-1:0]        r_leb, w_leb_nxt;
  logic [OBU_SIZE_W-1:0]        r_pay_rem, w_pay_rem_nxt;
  logic                         r_first, w_first_nxt;
  logic [PARSER_DATA_WIDTH-1:0] r_acc, w_acc_nxt, w_acc_ins;
  logic [CNT_W-1:0]             r_acc_cnt, w_acc_cnt_nxt, w_ins_cnt;
  obu_word_t                    r_pend, w_pend_nxt;
  logic                         r_pend_vld, w_pend_vld_nxt;
  logic                         r_cmd_ready, r_pay_ready;
  logic [PARSER_DATA_WIDTH-1:0] r_out_data;
  logic                         r_out_push, r_out_start, r_out_last;
  logic [LAST_LEN_W-1:0]        r_out_last_len;

  logic                         w_emit, w_final, w_push, w_pend_free, w_room;
  logic [BYTE_W-1:0]            w_byte;
  logic                         w_ext_flag;
  logic [BYTE_W-1:0]            w_ext_byte;
  logic                         w_cmd_acc;

  assign w_cmd_acc = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;

`ifdef OBU_WRITER_EXT_HDR_EN
  logic              r_ext_en;
  logic [BYTE_W-1:0] r_ext_byte;

  // Extension fields captured with the command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_en   <= 1'b0;
      r_ext_byte <= '0;
    end else if (w_cmd_acc) begin
      r_ext_en   <= cmd_ext_en;
      r_ext_byte <= {cmd_temporal_id, cmd_spatial_id, 3'b000};
    end
  end

  assign w_ext_flag = r_ext_en;
  assign w_ext_byte = r_ext_byte;
`else
  assign w_ext_flag = 1'b0;
  assign w_ext_byte = '0;
`endif

  // Next-state, byte generation, accumulator and pending-word control.
  always_comb begin
    w_state_nxt   = r_state;
    w_leb_nxt     = r_leb;
    w_pay_rem_nxt = r_pay_rem;
    w_first_nxt   = r_first;
    w_emit        = 1'b0;
    w_final       = 1'b0;
    w_byte        = '0;
    w_push        = r_pend_vld && !out_full;
    w_pend_free   = !r_pend_vld || w_push;
    w_room        = (r_acc_cnt != ACC_FULL);

    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          w_state_nxt   = S_HDR;
          w_leb_nxt     = cmd_size;
          w_pay_rem_nxt = cmd_size;
          w_first_nxt   = 1'b1;
        end
      end
      S_HDR: begin
        if (w_room) begin
          w_emit      = 1'b1;
          w_byte      = {1'b0, r_type, w_ext_flag, 1'b1, 1'b0};
          w_state_nxt = w_ext_flag ? S_EXT : S_SIZE;
        end
      end
      S_EXT: begin
        if (w_room) begin
          w_emit      = 1'b1;
          w_byte      = w_ext_byte;
          w_state_nxt = S_SIZE;
        end
      end
      S_SIZE: begin
        // Minimal LEB128: continuation bit set while higher groups remain.
        if (w_room) begin
          w_emit    = 1'b1;
          w_byte    = {(r_leb[OBU_SIZE_W-1:7] != '0), r_leb[6:0]};
          w_leb_nxt = r_leb >> 7;
          if (r_leb[OBU_SIZE_W-1:7] == '0) begin
            if (r_pay_rem != '0) begin
              w_state_nxt = S_PAYLOAD;
            end else begin
              w_state_nxt = S_FLUSH;
              w_final     = 1'b1;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (r_pay_ready && pay_valid) begin
          w_emit        = 1'b1;
          w_byte        = pay_byte;
          w_pay_rem_nxt = r_pay_rem - OBU_SIZE_W'(1);
          if (r_pay_rem == OBU_SIZE_W'(1)) begin
            w_state_nxt = S_FLUSH;
            w_final     = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (w_push && r_pend.last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Bytes fill from the MSB end, so unused low bytes stay zero.
    w_acc_ins = r_acc | ({w_byte, {(PARSER_DATA_WIDTH-BYTE_W){1'b0}}} >> {r_acc_cnt, 3'b000});
    w_ins_cnt = CNT_W'(r_acc_cnt + CNT_W'(1));

    w_acc_nxt      = r_acc;
    w_acc_cnt_nxt  = r_acc_cnt;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld && !w_push;

    if (w_emit) begin
      if (w_ins_cnt == ACC_FULL && w_pend_free) begin
        w_pend_nxt     = '{data: w_acc_ins, start: r_first, last: w_final, len: '0};
        w_pend_vld_nxt = 1'b1;
        w_acc_nxt      = '0;
        w_acc_cnt_nxt  = '0;
        w_first_nxt    = 1'b0;
      end else begin
        w_acc_nxt     = w_acc_ins;
        w_acc_cnt_nxt = w_ins_cnt;
      end
    end else if (w_pend_free &&
                 (r_acc_cnt == ACC_FULL || (r_state == S_FLUSH && r_acc_cnt != '0))) begin
      // Full word held back by a stall, or the final partial word in FLUSH.
      w_pend_nxt.data  = r_acc;
      w_pend_nxt.start = r_first;
      w_pend_nxt.last  = (r_state == S_FLUSH);
      w_pend_nxt.len   = (r_acc_cnt == ACC_FULL) ? '0 : LAST_LEN_W'({r_acc_cnt, 3'b000});
      w_pend_vld_nxt   = 1'b1;
      w_acc_nxt        = '0;
      w_acc_cnt_nxt    = '0;
      w_first_nxt      = 1'b0;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_type         <= '0;
      r_leb          <= '0;
      r_pay_rem      <= '0;
      r_first        <= 1'b0;
      r_acc          <= '0;
      r_acc_cnt      <= '0;
      r_pend         <= '0;
      r_pend_vld     <= 1'b0;
      r_cmd_ready    <= 1'b0;
      r_pay_ready    <= 1'b0;
      r_out_data     <= '0;
      r_out_push     <= 1'b0;
      r_out_start    <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_last_len <= '0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_cmd_acc) r_type <= cmd_obu_type;
      r_leb       <= w_leb_nxt;
      r_pay_rem   <= w_pay_rem_nxt;
      r_first     <= w_first_nxt;
      r_acc       <= w_acc_nxt;
      r_acc_cnt   <= w_acc_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      // Ready for next cycle only if the accumulator will have room.
      r_pay_ready <= (w_state_nxt == S_PAYLOAD) && (w_acc_cnt_nxt != ACC_FULL);
      r_out_push  <= w_push;
      if (w_push) r_out_data <= r_pend.data;
      r_out_start    <= w_push && r_pend.start;
      r_out_last     <= w_push && r_pend.last;
      r_out_last_len <= (w_push && r_pend.last) ? r_pend.len : '0;
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign pay_ready    = r_pay_ready;
  assign out_data     = r_out_data;
  assign out_push     = r_out_push;
  assign out_start    = r_out_start;
  assign out_last     = r_out_last;
  assign out_last_len = r_out_last_len;

endmodule

// File: tb/tb_obu_stream_writer.sv
// ---------------------------------------------------------------------------
// tb_obu_stream_writer
// Purpose: randomized and directed stimulus for obu_stream_writer, checked
// against a byte-list model of each OBU chopped into 4-byte words.
// Build with OBU_WRITER_EXT_HDR_EN to cover the extension header.
// ---------------------------------------------------------------------------
module tb_obu_stream_writer;
  import obu_stream_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_obu_type;
  logic [27:0] cmd_size;
  logic        cmd_ext_en;
  logic [2:0]  cmd_temporal_id;
  logic [1:0]  cmd_spatial_id;
  logic        pay_valid;
  logic        pay_ready;
  logic [7:0]  pay_byte;
  logic [31:0] out_data;
  logic        out_push;
  logic        out_full;
  logic        out_start;
  logic        out_last;
  logic [4:0]  out_last_len;

  always #5 clk = ~clk;

  obu_stream_writer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_obu_type    (cmd_obu_type),
    .cmd_size        (cmd_size),
`ifdef OBU_WRITER_EXT_HDR_EN
    .cmd_ext_en      (cmd_ext_en),
    .cmd_temporal_id (cmd_temporal_id),
    .cmd_spatial_id  (cmd_spatial_id),
`endif
    .pay_valid       (pay_valid),
    .pay_ready       (pay_ready),
    .pay_byte        (pay_byte),
    .out_data        (out_data),
    .out_push        (out_push),
    .out_full        (out_full),
    .out_start       (out_start),
    .out_last        (out_last),
    .out_last_len    (out_last_len)
  );

  typedef struct {
    logic [31:0] data;
    logic        start;
    logic        last;
    logic [4:0]  len;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [7:0]  pay_q[$];
  int          push_cnt;
  logic [31:0] first_word;
  logic [4:0]  last_len_seen;
  logic [7:0]  first_pay;
  logic        prev_full = 1'b0;
  logic        drv_pay_v = 1'b0, obs_pay_r = 1'b0;
  logic        drv_cmd_v = 1'b0, obs_cmd_r = 1'b0;
  bit          cmd_taken = 1'b0;
  int          full_pct = 0;
  int          valid_pct = 100;
  int          force_full = 0;
  bit          force_valid = 1'b0;
  bit          stall_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: account for the handshakes of the edge just passed, check
  // any push against the model, then drive the next cycle's inputs.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (drv_pay_v && obs_pay_r) void'(pay_q.pop_front());
    if (drv_cmd_v && obs_cmd_r) begin
      cmd_taken = 1'b1;
      cmd_valid = 1'b0;
      check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    end
    if (out_push) begin
      check("push_while_full", 32'(prev_full), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_push", 32'(out_push), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("word_data", out_data, e.data);
        check("word_start", 32'(out_start), 32'(e.start));
        check("word_last", 32'(out_last), 32'(e.last));
        if (e.last) check("word_last_len", 32'(out_last_len), 32'(e.len));
      end
      if (push_cnt == 0) first_word = out_data;
      if (out_last) last_len_seen = out_last_len;
      push_cnt++;
    end
    if (pay_ready) check("pay_ready_window", 32'(cmd_taken && pay_q.size() != 0), 32'd1);
    if (stall_chk) begin
      check("stall_pay_ready", 32'(pay_ready), 32'd0);
      stall_chk   = 1'b0;
      force_valid = 1'b0;
    end
    obs_pay_r = pay_ready;
    obs_cmd_r = cmd_ready;
    pay_valid = (pay_q.size() != 0) &&
                (force_valid || ($urandom % 100) < 32'(valid_pct));
    pay_byte  = pay_valid ? pay_q[0] : 8'($urandom);
    drv_pay_v = pay_valid;
    if (force_full > 0) begin
      out_full = 1'b1;
      if (force_full == 1) stall_chk = 1'b1;
      force_full--;
    end else begin
      out_full = ($urandom % 100) < 32'(full_pct);
    end
    prev_full = out_full;
    drv_cmd_v = cmd_valid;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_flags", {27'd0, out_push, out_start, out_last, pay_ready, 1'b0}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last_len", 32'(out_last_len), 32'd0);
    exp_q.delete();
    pay_q.delete();
    cmd_valid   = 1'b0;
    pay_valid   = 1'b0;
    out_full    = 1'b0;
    prev_full   = 1'b0;
    drv_pay_v   = 1'b0;
    drv_cmd_v   = 1'b0;
    cmd_taken   = 1'b0;
    force_full  = 0;
    force_valid = 1'b0;
    stall_chk   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Build the OBU byte list, queue its expected words, then run it.
  task automatic run_cmd(input logic [3:0] typ, input int size, input bit ext_en,
                         input logic [2:0] tid, input logic [1:0] sid, input bit fixed,
                         input int hold_at, input int abort_at);
    logic [7:0] bytes[$];
    logic [7:0] b;
    exp_t       e;
    int         v;
    int         n;
    bit         done;
    bit         hold_done;
    pay_q.delete();
    for (int i = 0; i < size; i++)
      pay_q.push_back(fixed ? 8'(8'hAA + 8'h11 * i) : 8'($urandom));
    bytes.push_back({1'b0, typ, ext_en, 1'b1, 1'b0});
    if (ext_en) bytes.push_back({tid, sid, 3'b000});
    v = size;
    do begin
      b = 8'(v % 128);
      v = v / 128;
      if (v != 0) b = b | 8'h80;
      bytes.push_back(b);
    end while (v != 0);
    foreach (pay_q[i]) bytes.push_back(pay_q[i]);
    n = bytes.size();
    for (int i = 0; i < n; i += 4) begin
      e.data = '0;
      for (int k = 0; k < 4; k++)
        if (i + k < n) e.data[31-8*k -: 8] = bytes[i+k];
      e.start = (i == 0);
      e.last  = (i + 4 >= n);
      e.len   = e.last ? 5'(((n - i) % 4) * 8) : 5'd0;
      exp_q.push_back(e);
    end
    first_pay       = (size > 0) ? pay_q[0] : 8'd0;
    push_cnt        = 0;
    first_word      = '0;
    last_len_seen   = '0;
    cmd_taken       = 1'b0;
    cmd_obu_type    = typ;
    cmd_size        = 28'(size);
    cmd_ext_en      = ext_en;
    cmd_temporal_id = tid;
    cmd_spatial_id  = sid;
    cmd_valid       = 1'b1;
    drv_cmd_v       = 1'b1;
    obs_cmd_r       = cmd_ready;
    done      = 1'b0;
    hold_done = 1'b0;
    for (int c = 0; c < 40000 && !done; c++) begin
      step();
      if (cmd_taken && hold_at >= 0 && !hold_done && size - pay_q.size() >= hold_at) begin
        force_full  = 10;
        force_valid = 1'b1;
        hold_done   = 1'b1;
      end
      if (cmd_taken && abort_at >= 0 && size - pay_q.size() >= abort_at) begin
        do_reset();
        return;
      end
      if (cmd_taken && pay_q.size() == 0 && exp_q.size() == 0 && force_full == 0 && !stall_chk)
        done = 1'b1;
    end
    if (!done) begin
      check("cmd_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    for (int c = 0; c < 4 && !cmd_ready; c++) step();
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int sz;
    int r;
    bit ext;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_obu_type = '0; cmd_size = '0;
    cmd_ext_en = 1'b0; cmd_temporal_id = '0; cmd_spatial_id = '0;
    pay_valid = 1'b0; pay_byte = '0; out_full = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_push", 32'(out_push), 32'd0);
    check("reset_data", out_data, 32'd0);
    check("reset_pay_ready", 32'(pay_ready), 32'd0);
    rst_n = 1'b1;
    step();
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // Short OBU with a partial final word.
    run_cmd(4'd1, 3, 1'b0, 3'd0, 2'd0, 1'b1, -1, -1);
    check("t1_first", first_word, 32'h0A03AABB);
    check("t1_pushes", 32'(push_cnt), 32'd2);
    check("t1_last_len", 32'(last_len_seen), 32'd8);

    // Empty payload: header and size only.
    run_cmd(4'd2, 0, 1'b0, 3'd0, 2'd0, 1'b0, -1, -1);
    check("t2_first", first_word, 32'h12000000);
    check("t2_pushes", 32'(push_cnt), 32'd1);
    check("t2_last_len", 32'(last_len_seen), 32'd16);

    // Two-byte LEB size under random backpressure.
    full_pct = 30; valid_pct = 70;
    run_cmd(4'd6, 200, 1'b0, 3'd0, 2'd0, 1'b0, -1, -1);
    check("t3_first_hi", 32'(first_word[31:8]), 32'h32C801);
    check("t3_first_lo", 32'(first_word[7:0]), 32'(first_pay));
    check("t3_pushes", 32'(push_cnt), 32'd51);
    check("t3_last_len", 32'(last_len_seen), 32'd24);

    // Downstream full held for ten cycles mid-payload.
    full_pct = 0; valid_pct = 100;
    run_cmd(4'd5, 100, 1'b0, 3'd0, 2'd0, 1'b0, 20, -1);

    // Reset mid-payload, then the short OBU must come out unchanged.
    run_cmd(4'd3, 50, 1'b0, 3'd0, 2'd0, 1'b0, -1, 10);
    run_cmd(4'd1, 3, 1'b0, 3'd0, 2'd0, 1'b1, -1, -1);
    check("t5_first", first_word, 32'h0A03AABB);
    check("t5_pushes", 32'(push_cnt), 32'd2);

`ifdef OBU_WRITER_EXT_HDR_EN
    run_cmd(4'd1, 3, 1'b1, 3'd2, 2'd1, 1'b1, -1, -1);
    check("t6_ext_first", first_word, 32'h0E4803AA);
`endif

    // Random commands around the LEB byte boundaries.
    for (int it = 0; it < 30; it++) begin
      full_pct  = int'($urandom % 40);
      valid_pct = 40 + int'($urandom % 61);
      r = int'($urandom % 10);
      if (r < 6)      sz = int'($urandom % 12);
      else if (r < 9) sz = int'($urandom % 300);
      else            sz = 127 + int'($urandom % 3);
      ext = 1'b0;
`ifdef OBU_WRITER_EXT_HDR_EN
      ext = 1'($urandom);
`endif
      run_cmd(4'($urandom), sz, ext, 3'($urandom), 2'($urandom), 1'b0, -1, -1);
    end

    // Three-byte LEB size.
    full_pct = 0; valid_pct = 100;
    run_cmd(4'd4, 16384, 1'b0, 3'd0, 2'd0, 1'b0, -1, -1);
    check("t7_first_hi", 32'(first_word[31:8]), 32'h228080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obu_stream_writer.md
OBU_STREAM_WRITER -- requirements
Module: obu_stream_writer

Interface
REQ-001 SHALL use no module parameters; word width is the package constant PARSER_DATA_WIDTH, default 32, meaning the output word size in bits.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  OBU command valid.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_obu_type  in  4  AV1 obu_type.
REQ-007 cmd_size  in  28  payload byte count (0..2^28-1).
REQ-008 pay_valid / pay_byte  in  1 / 8  payload byte stream.
REQ-009 pay_ready  out  1  payload byte consumed when pay_valid && pay_ready.
REQ-010 out_data  out  32  packed word; first stream byte in [31:24].
REQ-011 out_push  out  1  one-cycle push of out_data into downstream FIFO.
REQ-012 out_full  in  1  downstream FIFO full; no push while high.
REQ-013 out_start / out_last  out  1 / 1  first / final word of the current OBU, valid with out_push.
REQ-014 out_last_len  out  5  valid bits in the final word: 8, 16, 24, or 0 meaning all 32; valid with out_push && out_last.

Function
REQ-015 SHALL emit per command: header byte {0, type[3:0], ext_flag, 1, 0}, optional extension byte, minimal LEB128 of cmd_size (7 bits per byte, LSB group first, bit7 = continuation, 1-4 bytes), then exactly cmd_size payload bytes.
REQ-016 FSM states: IDLE, HDR, EXT, SIZE, PAYLOAD, FLUSH; IDLE->HDR on command accept; HDR->EXT when ext enabled, else ->SIZE; EXT->SIZE; SIZE->PAYLOAD after the last LEB byte if cmd_size>0, else ->FLUSH; PAYLOAD->FLUSH after the final payload byte; FLUSH->IDLE once the final word is pushed.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command presented in any other state is held off.
REQ-018 SHALL place at most one byte per cycle into a 4-byte accumulator; on the 4th byte the accumulator moves to a pending output word register.
REQ-019 out_push SHALL assert for exactly one cycle when a pending word exists and out_full=0; earliest is the cycle after the 4th byte is accepted.
REQ-020 When a word is pending and the accumulator is full, SHALL stall (pay_ready=0, header/size generation frozen); no byte is lost, duplicated, or reordered.
REQ-021 pay_ready SHALL be 1 only in PAYLOAD when not stalled.
REQ-022 In FLUSH a partial accumulator SHALL be pushed zero-padded in its low bytes, with out_last=1 and out_last_len=8*valid_bytes; a full word ending the OBU gives out_last_len=0.
REQ-023 Every OBU SHALL start on a new word; out_start=1 on its first pushed word; out_start and out_last both 1 for single-word OBUs.
REQ-024 The 28-bit payload remaining counter SHALL decrement per accepted payload byte and never wrap.

Reset
REQ-025 On rst_n low: state IDLE; out_push, out_start, out_last, pay_ready = 0; out_data = 0; out_last_len = 0; accumulator and pending word discarded; cmd_ready = 1 from the first clock after release.
REQ-026 Reset mid-OBU SHALL abandon the OBU; no partial word is pushed afterwards.

Configuration
REQ-027 Macro OBU_WRITER_EXT_HDR_EN: when defined, adds inputs cmd_ext_en (1), cmd_temporal_id (3), cmd_spatial_id (2); when cmd_ext_en=1, ext_flag=1 and extension byte {tid[2:0], sid[1:0], 000} follows the header.
REQ-028 Without the macro, those ports are absent, ext_flag is always 0, and the EXT state is never entered.

Verification
REQ-029 type=1, size=3, payload AA BB CC -> push 0x0A03AABB (start=1, last=0), then 0xCC000000 (last=1, last_len=8).
REQ-030 type=2, size=0 -> single push 0x12000000 with start=1, last=1, last_len=16.
REQ-031 type=6, size=200 -> first word 0x32C801xx (xx = first payload byte); 51 pushes total; last_len=24.
REQ-032 out_full held high 10 cycles mid-payload -> no out_push, pay_ready=0 once stalled; all bytes arrive in order after release.
REQ-033 rst_n pulsed mid-payload -> outputs 0 immediately; next command type=1, size=3 produces REQ-029 output exactly.
REQ-034 With OBU_WRITER_EXT_HDR_EN: type=1, ext_en=1, tid=2, sid=1, size=3 -> first word 0x0E4803AA.
